// File: rtl/turbo_block_receiver.sv
// Turbo block receiver: collects 8 {p2,p1,sys} symbols, re-encodes, counts parity errors.
// Optional failed-block counter enabled by TURBO_RX_ERR_STATS_EN.
module turbo_block_receiver #(
  parameter logic [3:0] G1         = 4'b1011,
  parameter logic [3:0] G2         = 4'b1101,
  parameter int         INTLV_MULT = 5,
  parameter int         INTLV_OFFS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       sof,
  input  logic [2:0] sym,
  output logic       busy,
  output logic       out_valid,
  output logic [7:0] data_out,
  output logic [3:0] p1_err_cnt,
  output logic [3:0] p2_err_cnt,
  output logic       block_ok,
  output logic [7:0] err_blocks
);

  typedef enum logic [1:0] {
    IDLE, COLLECT, CHECK, DONE
  } state_t;

  state_t     state;
  logic [7:0] sys_q, p1_q, p2_q;
  logic [2:0] cnt, k;
  logic [2:0] sr1, sr2;
  logic [3:0] c1, c2;

  function automatic logic [2:0] intlv(input logic [2:0] kk);
    int t;
    t = INTLV_MULT * int'(kk) + INTLV_OFFS;
    return t[2:0];
  endfunction

  logic [2:0] ik;
  logic [3:0] v1, v2;
  logic       m1, m2, ok_now;

  always_comb begin
    ik     = intlv(k);
    v1     = {sr1, sys_q[k]};
    v2     = {sr2, sys_q[ik]};
    m1     = (^(v1 & G1)) != p1_q[k];
    m2     = (^(v2 & G2)) != p2_q[k];
    ok_now = (c1 == 4'd0) && (c2 == 4'd0);
  end

  assign busy = (state == CHECK) || (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sys_q      <= '0;
      p1_q       <= '0;
      p2_q       <= '0;
      cnt        <= '0;
      k          <= '0;
      sr1        <= '0;
      sr2        <= '0;
      c1         <= '0;
      c2         <= '0;
      out_valid  <= 1'b0;
      data_out   <= '0;
      p1_err_cnt <= '0;
      p2_err_cnt <= '0;
      block_ok   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid && sof) begin
            sys_q[0] <= sym[0];
            p1_q[0]  <= sym[1];
            p2_q[0]  <= sym[2];
            cnt      <= 3'd1;
            state    <= COLLECT;
          end
        end
        COLLECT: begin
          if (in_valid) begin
            if (sof) begin
              // resync: this symbol becomes bit 0
              sys_q[0] <= sym[0];
              p1_q[0]  <= sym[1];
              p2_q[0]  <= sym[2];
              cnt      <= 3'd1;
            end else begin
              sys_q[cnt] <= sym[0];
              p1_q[cnt]  <= sym[1];
              p2_q[cnt]  <= sym[2];
              cnt        <= cnt + 3'd1;
              if (cnt == 3'd7) begin
                state <= CHECK;
                k     <= '0;
                sr1   <= '0;
                sr2   <= '0;
                c1    <= '0;
                c2    <= '0;
              end
            end
          end
        end
        CHECK: begin
          sr1 <= v1[2:0];
          sr2 <= v2[2:0];
          c1  <= c1 + {3'b000, m1};
          c2  <= c2 + {3'b000, m2};
          k   <= k + 3'd1;
          if (k == 3'd7) state <= DONE;
        end
        DONE: begin
          data_out   <= sys_q;
          p1_err_cnt <= c1;
          p2_err_cnt <= c2;
          block_ok   <= ok_now;
          out_valid  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TURBO_RX_ERR_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_blocks <= '0;
    end else if (state == DONE && !ok_now
                 && err_blocks != 8'hFF) begin
      err_blocks <= err_blocks + 8'd1;
    end
  end
`else
  assign err_blocks = '0;
`endif

endmodule

// File: tb/tb_turbo_block_receiver.sv
// Scoreboard bench for turbo_block_receiver: directed blocks,
// expected results queued at issue, checked by an independent monitor.
module tb_turbo_block_receiver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       sof;
  logic [2:0] sym;
  logic       busy;
  logic       out_valid;
  logic [7:0] data_out;
  logic [3:0] p1_err_cnt;
  logic [3:0] p2_err_cnt;
  logic       block_ok;
  logic [7:0] err_blocks;

  turbo_block_receiver dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .sof        (sof),
    .sym        (sym),
    .busy       (busy),
    .out_valid  (out_valid),
    .data_out   (data_out),
    .p1_err_cnt (p1_err_cnt),
    .p2_err_cnt (p2_err_cnt),
    .block_ok   (block_ok),
    .err_blocks (err_blocks)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [3:0] c1;
    logic [3:0] c2;
    logic       ok;
    logic [7:0] eb;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   last_acc;
  int   eb_model = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: pops one expectation per result strobe
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("latency_cycle", cyc, e.cyc);
          chk("data_out", int'(data_out), int'(e.data));
          chk("p1_err_cnt", int'(p1_err_cnt), int'(e.c1));
          chk("p2_err_cnt", int'(p2_err_cnt), int'(e.c2));
          chk("block_ok", int'(block_ok), int'(e.ok));
          chk("err_blocks", int'(err_blocks), int'(e.eb));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sym(input logic [2:0] s, input logic f,
                          input int gap);
    in_valid = 1'b1;
    sof      = f;
    sym      = s;
    tick();
    last_acc = cyc;
    in_valid = 1'b0;
    sof      = 1'b0;
    sym      = 3'b000;
    repeat (gap) tick();
  endtask

  task automatic send_block(input logic [7:0] d, input logic [7:0] p1,
                            input logic [7:0] p2, input int gmax,
                            input logic [3:0] ec1, input logic [3:0] ec2);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      send_sym({p2[i], p1[i], d[i]}, i == 0,
               (i < 7 && gmax > 0) ? 1 + (i % gmax) : 0);
    end
    e.data = d;
    e.c1   = ec1;
    e.c2   = ec2;
    e.ok   = (ec1 == 0) && (ec2 == 0);
`ifdef TURBO_RX_ERR_STATS_EN
    if (!e.ok && eb_model < 255) eb_model++;
`endif
    e.eb   = 8'(eb_model);
    e.cyc  = last_acc + 9;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    chk("result_timeout", exp_q.size(), 0);
    tick();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_data_out"}, int'(data_out), 0);
    chk({tag, "_p1_cnt"}, int'(p1_err_cnt), 0);
    chk({tag, "_p2_cnt"}, int'(p2_err_cnt), 0);
    chk({tag, "_block_ok"}, int'(block_ok), 0);
    chk({tag, "_err_blocks"}, int'(err_blocks), 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sof      = 1'b0;
    sym      = 3'b000;
    repeat (3) tick();
    rst_n = 1'b1;
    check_zero("reset");

    // all-zero block
    send_block(8'h00, 8'h00, 8'h00, 0, 4'd0, 4'd0);
    drain();

    // impulse on sys0: p1 = 1,1,0,1,0.. ; p2 = 0,1,0,1,1,0..
    send_block(8'h01, 8'h0B, 8'h1A, 0, 4'd0, 4'd0);
    drain();

    // p1 of symbol 3 and p2 of symbol 4 flipped
    send_block(8'h01, 8'h03, 8'h0A, 0, 4'd1, 4'd1);
    drain();

    // sof reasserted at symbol 5 restarts the block
    for (int i = 0; i < 5; i++) send_sym(3'b111, i == 0, 0);
    send_block(8'h01, 8'h0B, 8'h1A, 0, 4'd0, 4'd0);
    drain();

    // symbols driven while busy must be ignored
    send_block(8'h03, 8'h1D, 8'h5A, 0, 4'd0, 4'd0);
    in_valid = 1'b1;
    sof      = 1'b1;
    sym      = 3'b111;
    chk("busy_after_sym7", int'(busy), 1);
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i < 8) chk("busy_during_check", int'(busy), 1);
    end
    in_valid = 1'b0;
    sof      = 1'b0;
    sym      = 3'b000;
    chk("busy_after_done", int'(busy), 0);
    drain();

    // sparse in_valid, gaps of 1..3 cycles
    send_block(8'h03, 8'h1D, 8'h5A, 3, 4'd0, 4'd0);
    drain();

    // reset in the middle of CHECK aborts the block
    for (int i = 0; i < 8; i++) send_sym({1'b1, 1'b0, i[0]}, i == 0, 0);
    repeat (3) tick();
    chk("busy_before_abort", int'(busy), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    eb_model = 0;
    check_zero("abort");
    repeat (12) tick();
    chk("abort_no_strobe", int'(out_valid), 0);

    send_block(8'h01, 8'h0B, 8'h1A, 0, 4'd0, 4'd0);
    drain();

    repeat (5) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/turbo_block_receiver.md
Name: turbo_block_receiver

Overview:
- Receive side of the 3-bit turbo symbol stream {p2, p1, sys}.
- Collects one 8-symbol block, takes the systematic bits as the hard-decision data byte, and re-encodes them locally with both constituent encoders (G1 = 1+D+D^3, G2 = 1+D^2+D^3) and the block interleaver.
- Compares the local parities against the received parities and reports the decoded byte plus per-encoder mismatch counts.
- Sits between the symbol input pins and the top-level output mux, alongside the encoder.

Parameters:
- G1, 4'b1011, tap mask for parity 1 (bit3 = oldest).
- G2, 4'b1101, tap mask for parity 2.
- INTLV_MULT, 5, interleaver multiplier; must be odd.
- INTLV_OFFS, 3, interleaver offset. Interleaved index i(k) = (INTLV_MULT*k + INTLV_OFFS) mod 8.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  sym valid this cycle.
- sof  in  1  start-of-block; qualifies the symbol as bit 0.
- sym  in  3  [0] = sys, [1] = p1, [2] = p2.
- busy  out  1  high in CHECK/DONE; symbols are dropped while high.
- out_valid  out  1  one-cycle result strobe.
- data_out  out  8  decoded byte; data_out[k] = sys of symbol k.
- p1_err_cnt  out  4  count of p1 mismatches (0..8).
- p2_err_cnt  out  4  count of p2 mismatches (0..8).
- block_ok  out  1  high when both error counts are 0.
- err_blocks  out  8  failed-block counter (see Optional Feature).

Behaviour:
- One clock domain. Reset is synchronous and active-low on rst_n.
- On reset, every output is 0, the FSM goes to IDLE, and all buffers, counters and shift registers clear.
- FSM states:
  - IDLE: in_valid && sof stores sym as symbol 0, sets cnt = 1, goes to COLLECT. in_valid without sof is ignored.
  - COLLECT: each in_valid stores sym at index cnt, then cnt++. If sof arrives with in_valid, collection restarts: that symbol becomes symbol 0 and cnt = 1 (resync). When symbol 7 is stored, go to CHECK with k = 0 and sr1 = sr2 = 0. Gaps in in_valid are allowed.
  - CHECK: one step per cycle for k = 0..7.
    - sr1 <= {sr1[2:0], sys[k]}; expected p1 = ^({sr1[2:0], sys[k]} & G1).
    - sr2 <= {sr2[2:0], sys[i(k)]}; expected p2 = ^({sr2[2:0], sys[i(k)]} & G2).
    - Increment the p1/p2 mismatch counters on inequality with the received bit.
    - After k = 7, go to DONE.
  - DONE: load data_out, both counts and block_ok; pulse out_valid for one cycle; return to IDLE.
- Latency: out_valid rises exactly 9 cycles after the cycle that accepted symbol 7.
- Result outputs hold their values until the next DONE. out_valid is low at all other times.
- busy = 1 in CHECK and DONE. in_valid/sof are ignored in those states with no error flag. A new block may start in the cycle after out_valid.
- Counters are 4 bits wide and cannot wrap, since the maximum value is 8.
- Reset in any state aborts the block with no out_valid.

Optional Feature:
- Macro: TURBO_RX_ERR_STATS_EN.
- Defined: err_blocks is an 8-bit counter that increments at DONE when block_ok = 0, saturates at 255, and clears only on reset.
- Undefined: err_blocks is tied to 0 and no counter logic is generated.

Test Plan:
- Reset, then 8 symbols of 3'b000 with sof on the first -> out_valid 9 cycles after the last symbol; data_out = 0x00, counts 0/0, block_ok = 1.
- Data 0x01 (sys = 1 on symbol 0 only), p1 bits k0..7 = 1,1,0,1,0,0,0,0, p2 bits k0..7 = 0,1,0,1,1,0,0,0 -> data_out = 0x01, counts 0/0, block_ok = 1.
- Same block with p1 of symbol 3 flipped and p2 of symbol 4 flipped -> p1_err_cnt = 1, p2_err_cnt = 1, block_ok = 0. With the macro defined, err_blocks goes 0 -> 1.
- sof reasserted at symbol 5 of a block, followed by 7 more symbols -> exactly one out_valid, computed from the restarted block only.
- Symbols driven during busy -> ignored; the next block still decodes correctly. Sparse in_valid (gaps of 1–3 cycles) -> same result as back-to-back.
- rst_n low during CHECK -> no out_valid and all outputs 0; a following clean block decodes normally.
